led_row_serializer: RTL and testbench



---
 rtl/led_row_serializer_if.sv | 27 ++
 rtl/led_row_serializer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_led_row_serializer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_row_serializer_if.sv
// Row-load handshake between the display driver's row control and led_row_serializer.
// master = upstream row control, slave = serializer.
interface led_row_serializer_if #(
  parameter int NUM_COLS = 64
);
  logic                     enable_in;
  logic                     ready_out;
  logic [3:0]               row_addr_in;
  logic [2:0][NUM_COLS-1:0] col_top_in;
  logic [2:0][NUM_COLS-1:0] col_bot_in;

  modport master (
    output enable_in,
    output row_addr_in,
    output col_top_in,
    output col_bot_in,
    input  ready_out
  );

  modport slave (
    input  enable_in,
    input  row_addr_in,
    input  col_top_in,
    input  col_bot_in,
    output ready_out
  );
endinterface

// File: rtl/led_row_serializer.sv
// HUB75-style row output stage: shifts one captured row out on bit_clk_out, then latches it.
// Define LED_ROW_SERIALIZER_BLANK_EN to add panel blanking (BLANK/UNBLANK) around the latch.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a row; rgb outputs hold the last column 0
// ST_SHIFT   | clock out columns NUM_COLS-1 down to 0
// ST_BLANK   | panel dark, new address driven (BLANK_EN builds only)
// ST_LATCH   | latch pulse high
// ST_UNBLANK | panel lit again before returning idle (BLANK_EN builds only)
module led_row_serializer #(
  parameter int NUM_COLS     = 64,
  parameter int WRITE_FREQ   = 1_000_000,
  parameter int SYS_CLK_FREQ = 100_000_000
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  led_row_serializer_if.slave    bus,
  output logic [2:0]             rgb_top_out,
  output logic [2:0]             rgb_bot_out,
  output logic                   bit_clk_out,
  output logic                   latch_enable_out,
  output logic                   output_enable_out,
  output logic [3:0]             addr_out,
  output logic                   row_done_out
);

  localparam int HALF_RAW = SYS_CLK_FREQ / (2 * WRITE_FREQ);
  localparam int HALF_CYC = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DIV_W    = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_UNBLANK = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [DIV_W-1:0]         r_div;
  logic                     w_tick;
  logic                     w_accept;
  logic                     w_fall;
  logic                     w_shift_done;
  logic                     w_finish;

  logic [IDX_W-1:0]         r_col_idx;
  logic [IDX_W-1:0]         w_idx_dec;

  logic [2:0][NUM_COLS-1:0] r_top;
  logic [2:0][NUM_COLS-1:0] r_bot;
  logic [3:0]               r_addr_cap;
  logic [3:0]               r_addr;
  logic [2:0]               r_rgb_top;
  logic [2:0]               r_rgb_bot;
  logic                     r_bit_clk;
  logic                     r_row_done;

  logic                     w_ready;
  logic                     w_latch;

  assign w_accept     = (r_state == ST_IDLE) && bus.enable_in;
  assign w_tick       = (r_state != ST_IDLE) && (r_div == DIV_LAST);
  assign w_fall       = (r_state == ST_SHIFT) && w_tick && r_bit_clk;
  assign w_shift_done = w_fall && (r_col_idx == '0);
  assign w_idx_dec    = r_col_idx - 1'b1;

`ifdef LED_ROW_SERIALIZER_BLANK_EN
  assign w_finish = (r_state == ST_UNBLANK) && w_tick;
`else
  assign w_finish = (r_state == ST_LATCH) && w_tick;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable_in) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_shift_done) begin
`ifdef LED_ROW_SERIALIZER_BLANK_EN
          w_state_next = ST_BLANK;
`else
          w_state_next = ST_LATCH;
`endif
        end
      end
`ifdef LED_ROW_SERIALIZER_BLANK_EN
      ST_BLANK: begin
        if (w_tick) begin
          w_state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (w_tick) begin
          w_state_next = ST_UNBLANK;
        end
      end
      ST_UNBLANK: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
        end
      end
`else
      ST_LATCH: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef LED_ROW_SERIALIZER_BLANK_EN
  logic r_lit;
  logic w_oe;

  // The previous row keeps displaying while the next one shifts, once one has been latched.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_lit <= 1'b0;
    end else if ((r_state == ST_LATCH) && w_tick) begin
      r_lit <= 1'b1;
    end
  end

  always_comb begin
    w_ready = 1'b0;
    w_latch = 1'b0;
    w_oe    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        w_oe    = r_lit;
      end
      ST_SHIFT: begin
        w_oe = r_lit;
      end
      ST_LATCH: begin
        w_latch = 1'b1;
      end
      ST_UNBLANK: begin
        w_oe = 1'b1;
      end
      default: begin
        w_oe = 1'b0;
      end
    endcase
  end

  assign output_enable_out = w_oe;
`else
  always_comb begin
    w_ready = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
      end
      ST_LATCH: begin
        w_latch = 1'b1;
      end
      default: begin
        w_latch = 1'b0;
      end
    endcase
  end

  assign output_enable_out = 1'b1;
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_div <= '0;
    end else if ((r_state == ST_IDLE) || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_top      <= '0;
      r_bot      <= '0;
      r_addr_cap <= '0;
    end else if (w_accept) begin
      r_top      <= bus.col_top_in;
      r_bot      <= bus.col_bot_in;
      r_addr_cap <= bus.row_addr_in;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_col_idx <= '0;
    end else if (w_accept) begin
      r_col_idx <= IDX_FIRST;
    end else if (w_fall && !w_shift_done) begin
      r_col_idx <= w_idx_dec;
    end
  end

  // Column 0 stays on the pins after the last falling edge until the next accept.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rgb_top <= '0;
      r_rgb_bot <= '0;
    end else if (w_accept) begin
      r_rgb_top <= {bus.col_top_in[2][NUM_COLS-1], bus.col_top_in[1][NUM_COLS-1],
                    bus.col_top_in[0][NUM_COLS-1]};
      r_rgb_bot <= {bus.col_bot_in[2][NUM_COLS-1], bus.col_bot_in[1][NUM_COLS-1],
                    bus.col_bot_in[0][NUM_COLS-1]};
    end else if (w_fall && !w_shift_done) begin
      r_rgb_top <= {r_top[2][w_idx_dec], r_top[1][w_idx_dec], r_top[0][w_idx_dec]};
      r_rgb_bot <= {r_bot[2][w_idx_dec], r_bot[1][w_idx_dec], r_bot[0][w_idx_dec]};
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_bit_clk <= 1'b0;
    end else if (w_accept) begin
      r_bit_clk <= 1'b0;
    end else if ((r_state == ST_SHIFT) && w_tick) begin
      r_bit_clk <= ~r_bit_clk;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_addr <= '0;
    end else if (w_shift_done) begin
      r_addr <= r_addr_cap;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_row_done <= 1'b0;
    end else begin
      r_row_done <= w_finish;
    end
  end

  assign bus.ready_out    = w_ready;
  assign latch_enable_out = w_latch;
  assign rgb_top_out      = r_rgb_top;
  assign rgb_bot_out      = r_rgb_bot;
  assign bit_clk_out      = r_bit_clk;
  assign addr_out         = r_addr;
  assign row_done_out     = r_row_done;

endmodule

// File: tb/tb_led_row_serializer.sv
// Self-checking bench for led_row_serializer: elapsed-cycle reference model plus directed checks.
module tb_led_row_serializer;
  localparam int N = 64;
  localparam int H = 50;
`ifdef LED_ROW_SERIALIZER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int S       = 2 * N * H;
  localparam int TOTAL   = S + (BLANK ? 3 * H : H);
  localparam int LAT_LIT = BLANK ? 6550 : 6450;
  localparam bit OE_RST  = BLANK ? 1'b0 : 1'b1;

  logic       clk_in   = 1'b0;
  logic       reset_in = 1'b0;
  logic [2:0] rgb_top_out;
  logic [2:0] rgb_bot_out;
  logic       bit_clk_out;
  logic       latch_enable_out;
  logic       output_enable_out;
  logic [3:0] addr_out;
  logic       row_done_out;

  led_row_serializer_if #(.NUM_COLS(N)) bus ();

  led_row_serializer #(
    .NUM_COLS(N), .WRITE_FREQ(1_000_000), .SYS_CLK_FREQ(100_000_000)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus),
    .rgb_top_out(rgb_top_out), .rgb_bot_out(rgb_bot_out), .bit_clk_out(bit_clk_out),
    .latch_enable_out(latch_enable_out), .output_enable_out(output_enable_out),
    .addr_out(addr_out), .row_done_out(row_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: what is on the pins is a function of cycles elapsed since accept.
  logic [2:0][N-1:0] m_top = '0;
  logic [2:0][N-1:0] m_bot = '0;
  logic [3:0] m_addr_cap = '0, m_addr_disp = '0;
  logic [2:0] m_hold_top = '0, m_hold_bot = '0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_lit = 1'b0;
  int         m_n = 0;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      m_top <= '0; m_bot <= '0; m_addr_cap <= '0; m_addr_disp <= '0;
      m_hold_top <= '0; m_hold_bot <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_lit <= 1'b0; m_n <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.enable_in) begin
          m_busy     <= 1'b1;
          m_n        <= 0;
          m_top      <= bus.col_top_in;
          m_bot      <= bus.col_bot_in;
          m_addr_cap <= bus.row_addr_in;
        end
      end else if (m_n + 1 == TOTAL) begin
        m_busy      <= 1'b0;
        m_done      <= 1'b1;
        m_lit       <= 1'b1;
        m_addr_disp <= m_addr_cap;
        m_hold_top  <= {m_top[2][0], m_top[1][0], m_top[0][0]};
        m_hold_bot  <= {m_bot[2][0], m_bot[1][0], m_bot[0][0]};
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  // {ready, rgb_top, rgb_bot, bit_clk, latch, oe, addr, done}
  function automatic logic [14:0] model_out();
    logic rdy, bc, le, oe;
    logic [3:0] ad;
    logic [2:0] rt, rb;
    int col, phase;
    rdy = !m_busy; bc = 1'b0; le = 1'b0; ad = m_addr_disp;
    rt = m_hold_top; rb = m_hold_bot;
    oe = BLANK ? m_lit : 1'b1;
    if (m_busy) begin
      if (m_n < S) begin
        bc  = ((m_n / H) % 2) == 1;
        col = N - 1 - (m_n / H) / 2;
      end else begin
        col   = 0;
        ad    = m_addr_cap;
        phase = (m_n - S) / H;
        if (BLANK) begin
          oe = (phase == 2);
          le = (phase == 1);
        end else begin
          le = 1'b1;
        end
      end
      rt = {m_top[2][col], m_top[1][col], m_top[0][col]};
      rb = {m_bot[2][col], m_bot[1][col], m_bot[0][col]};
    end
    return {rdy, rt, rb, bc, le, oe, ad, m_done};
  endfunction

  int n_cmp = 0, n_mis = 0;
  int bc_cnt = 0, le_pulses = 0, le_lit = 0, done_cnt = 0, le_run = 0, le_width = 0;
  logic [63:0] r_shift = '0;
  logic prev_bc = 1'b0, prev_le = 1'b0;
  bit sim_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_ready(input string name, input int budget, output int lat);
    lat = 0;
    while (!bus.ready_out && lat < budget) begin
      @(negedge clk_in);
      lat++;
    end
    if (!bus.ready_out) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic set_row(input logic [3:0] a);
    for (int c = 0; c < 3; c++) begin
      bus.col_top_in[c] = {$urandom(), $urandom()};
      bus.col_bot_in[c] = {$urandom(), $urandom()};
    end
    bus.row_addr_in = a;
  endtask

  task automatic pulse_enable();
    bus.enable_in = 1'b1;
    cycles(1);
    bus.enable_in = 1'b0;
  endtask

  initial begin
    bus.enable_in   = 1'b0;
    bus.row_addr_in = '0;
    bus.col_top_in  = '0;
    bus.col_bot_in  = '0;
    reset_in        = 1'b1;
    fork
      begin : compare_loop
        while (!sim_done) begin
          @(negedge clk_in);
          if (!reset_in)
            chk("cycle", {49'd0, bus.ready_out, rgb_top_out, rgb_bot_out, bit_clk_out,
                          latch_enable_out, output_enable_out, addr_out, row_done_out},
                {49'd0, model_out()});
          if (bit_clk_out && !prev_bc) begin
            bc_cnt++;
            r_shift = {r_shift[62:0], rgb_top_out[0]};
          end
          if (latch_enable_out && !prev_le) le_pulses++;
          if (latch_enable_out) le_run++;
          else if (prev_le) begin
            le_width = le_run;
            le_run   = 0;
          end
          if (latch_enable_out && output_enable_out) le_lit++;
          if (row_done_out) done_cnt++;
          prev_bc = bit_clk_out;
          prev_le = latch_enable_out;
        end
      end
      begin : stimulus
        int lat, b0, p0, d0, l0, k;
        cycles(4);
        #3 reset_in = 1'b0;
        cycles(1);
        chk("rst_ready", bus.ready_out, 1);
        chk("rst_pins", {rgb_top_out, rgb_bot_out, bit_clk_out, latch_enable_out, addr_out,
                         row_done_out}, 0);
        chk("rst_oe", output_enable_out, OE_RST);

        // Known R pattern must appear MSB-first on rising bit clocks.
        set_row(4'h5);
        bus.col_top_in[0] = 64'hA5A5_0000_FFFF_0001;
        b0 = bc_cnt;
        pulse_enable();
        wait_ready("t1_ready", TOTAL + 100, lat);
        chk("t1_latency", lat, LAT_LIT);
        cycles(2);
        chk("t1_bitclks", bc_cnt - b0, 64);
        chk("t1_r_bits", r_shift, 64'hA5A5_0000_FFFF_0001);
        chk("t1_addr", addr_out, 4'h5);
        chk("t1_oe_after", output_enable_out, 1);

        // Address captured at accept; later input changes must not leak through.
        set_row(4'hB);
        p0 = le_pulses; l0 = le_lit;
        pulse_enable();
        cycles(1000);
        set_row(4'h3);
        wait_ready("t2_ready", TOTAL, lat);
        cycles(2);
        chk("t2_addr", addr_out, 4'hB);
        chk("t2_latch_width", le_width, 50);
        chk("t2_latch_pulses", le_pulses - p0, 1);
`ifdef LED_ROW_SERIALIZER_BLANK_EN
        chk("t2_latch_while_lit", le_lit - l0, 0);
`endif

        // Requests while busy are dropped.
        set_row(4'h7);
        d0 = done_cnt; b0 = bc_cnt;
        pulse_enable();
        cycles(500);
        pulse_enable();
        cycles(2500);
        pulse_enable();
        wait_ready("t3_ready", TOTAL, lat);
        cycles(2);
        chk("t3_done_pulses", done_cnt - d0, 1);
        chk("t3_bitclks", bc_cnt - b0, 64);

        // enable held high: second row accepted in the cycle ready returns.
        set_row(4'h2);
        d0 = done_cnt; b0 = bc_cnt; p0 = le_pulses;
        bus.enable_in = 1'b1;
        cycles(1);
        wait_ready("t4_ready1", TOTAL + 10, lat);
        set_row(4'hE);
        cycles(1);
        chk("t4_second_accept", bus.ready_out, 0);
        bus.enable_in = 1'b0;
        wait_ready("t4_ready2", TOTAL + 10, lat);
        cycles(2);
        chk("t4_bitclks", bc_cnt - b0, 128);
        chk("t4_latch_pulses", le_pulses - p0, 2);
        chk("t4_done_pulses", done_cnt - d0, 2);
        chk("t4_addr", addr_out, 4'hE);

        // Reset at the 20th bit clock aborts the row with no latch.
        set_row(4'h9);
        b0 = bc_cnt; p0 = le_pulses;
        pulse_enable();
        k = 0;
        while ((bc_cnt - b0) < 20 && k < 5000) begin
          cycles(1);
          k++;
        end
        chk("t5_reach_20th_bitclk", ((bc_cnt - b0) >= 20), 1);
        #2 reset_in = 1'b1;
        #1;
        chk("t5_async_reset_pins", {bus.ready_out, rgb_top_out, rgb_bot_out, bit_clk_out,
                                    latch_enable_out, output_enable_out, addr_out, row_done_out},
            {1'b1, 3'b0, 3'b0, 1'b0, 1'b0, OE_RST, 4'h0, 1'b0});
        b0 = bc_cnt;
        cycles(3);
        #3 reset_in = 1'b0;
        cycles(1);
        chk("t5_ready_after", bus.ready_out, 1);
        cycles(5000);
        chk("t5_no_latch", le_pulses - p0, 0);
        chk("t5_no_bitclk", bc_cnt - b0, 0);

        // Random rows with random gaps and enable lengths.
        for (int r = 0; r < 3; r++) begin
          set_row(4'($urandom_range(0, 15)));
          cycles($urandom_range(0, 5));
          bus.enable_in = 1'b1;
          cycles($urandom_range(1, 3));
          bus.enable_in = 1'b0;
          wait_ready("rnd_ready", TOTAL, lat);
        end
        cycles(3);
        sim_done = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
